instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 148 ++++++++++++++
 tb/tb_instr_decode.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Single-slot ARM data-processing decode stage with a register scoreboard.
// Accepts one fetched instruction into a holding register, drops anything that
// is not a legal data-processing op, and holds RAW/WAW hazards until the
// pending register is retired.
//
// state | meaning
// EMPTY | holding register free, ready to accept
// STALL | legal instruction held, waiting on a pending register
// ISSUE | decoded instruction presented downstream (out_valid=1)
module instr_decode #(
  parameter int REG_N = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  addr_a,
  output logic [3:0]  addr_b,
  output logic [3:0]  addr_c,
  output logic        we_c,
  output logic [3:0]  alu_op,
  output logic        imm_en,
  output logic [31:0] imm_val,
  output logic        set_flags,
  output logic [31:0] out_pc,
  input  logic        retire_valid,
  input  logic [3:0]  retire_addr,
  output logic        illegal
);

  typedef enum logic [1:0] {EMPTY, STALL, ISSUE} state_t;

  state_t             state_q;
  logic [REG_N-1:0]   pending_q;
  logic               illegal_q;
  logic [3:0]         addr_a_q, addr_b_q, addr_c_q, alu_op_q;
  logic               we_c_q, imm_en_q, set_flags_q;
  logic [31:0]        imm_val_q, out_pc_q;

  logic               issue, accept;
  logic [3:0]         dec_op;
  logic               dec_we, dec_legal;
  logic [31:0]        dec_imm8, dec_imm;
  logic [4:0]         dec_rot;
  logic [REG_N-1:0]   set_vec, clr_vec, pend_nxt;
  logic [15:0]        pend_ext;
  logic               hz_in, hz_held;

  // Any register address (including r15, never tracked) indexes a 16-bit view.
  function automatic logic hazard(input logic [15:0] p, input logic [3:0] a,
                                  input logic [3:0] b, input logic [3:0] c,
                                  input logic ie, input logic we);
    return p[a] | (~ie & p[b]) | (we & p[c]);
  endfunction

  assign issue    = (state_q == ISSUE) && out_ready;
  assign in_ready = rst_n && ((state_q == EMPTY) || issue);
  assign accept   = in_valid && in_ready;

  // Decode of the incoming word: TST/TEQ/CMP/CMN (1000-1011) never write Rd.
  always_comb begin
    dec_op    = in_instr[24:21];
    dec_we    = (dec_op[3:2] != 2'b10);
    dec_legal = (in_instr[27:26] == 2'b00) && (in_instr[31:28] != 4'hF) &&
                (!dec_we || (32'(in_instr[15:12]) < REG_N));
    dec_imm8  = {24'd0, in_instr[7:0]};
    dec_rot   = {in_instr[11:8], 1'b0};
    dec_imm   = (dec_imm8 >> dec_rot) | (dec_imm8 << (6'd32 - {1'b0, dec_rot}));
  end

  // Next-cycle scoreboard: retire clears first so a same-cycle issue set wins;
  // hazards are judged against this value so a retire unblocks immediately.
  always_comb begin
    set_vec  = '0;
    clr_vec  = '0;
    pend_ext = '0;
    for (int i = 0; i < REG_N; i++) begin
      set_vec[i] = issue && we_c_q && (addr_c_q == 4'(i));
      clr_vec[i] = retire_valid && (retire_addr == 4'(i));
    end
    pend_nxt = (pending_q & ~clr_vec) | set_vec;
    for (int i = 0; i < REG_N; i++) pend_ext[i] = pend_nxt[i];
    hz_in   = hazard(pend_ext, in_instr[19:16], in_instr[3:0], in_instr[15:12],
                     in_instr[25], dec_we);
    hz_held = hazard(pend_ext, addr_a_q, addr_b_q, addr_c_q, imm_en_q, we_c_q);
  end

  // Decode FSM, holding register, scoreboard and discard pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      pending_q   <= '0;
      illegal_q   <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      alu_op_q    <= '0;
      we_c_q      <= 1'b0;
      imm_en_q    <= 1'b0;
      set_flags_q <= 1'b0;
      imm_val_q   <= '0;
      out_pc_q    <= '0;
    end else begin
      pending_q <= pend_nxt;
      illegal_q <= 1'b0;
      if (accept) begin
        if (!dec_legal) begin
          illegal_q <= 1'b1;
          state_q   <= EMPTY;
        end else begin
          addr_a_q    <= in_instr[19:16];
          addr_b_q    <= in_instr[3:0];
          addr_c_q    <= in_instr[15:12];
          alu_op_q    <= dec_op;
          we_c_q      <= dec_we;
          imm_en_q    <= in_instr[25];
          set_flags_q <= in_instr[20];
          imm_val_q   <= dec_imm;
          out_pc_q    <= in_pc;
          state_q     <= hz_in ? STALL : ISSUE;
        end
      end else begin
        case (state_q)
          STALL:   if (!hz_held) state_q <= ISSUE;
          ISSUE:   if (out_ready) state_q <= EMPTY;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign out_valid = (state_q == ISSUE);
  assign illegal   = illegal_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign addr_c    = addr_c_q;
  assign alu_op    = alu_op_q;
  assign we_c      = we_c_q;
  assign imm_en    = imm_en_q;
  assign set_flags = set_flags_q;
  assign imm_val   = imm_val_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed scenarios then randomized traffic, with a
// queue-based scoreboard fed at accept time and drained by an output monitor.
module tb_instr_decode;

  localparam int REG_N = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, retire_valid;
  logic        we_c, imm_en, set_flags, illegal;
  logic [31:0] in_instr, in_pc, imm_val, out_pc;
  logic [3:0]  addr_a, addr_b, addr_c, alu_op, retire_addr;

  int   n_chk = 0;
  int   n_pass = 0;
  bit   rnd_mode = 1'b0;
  logic [15:0] pend_m = '0;

  typedef struct packed {
    logic        ill;
    logic [3:0]  a, b, c;
    logic        we;
    logic [3:0]  op;
    logic        ie;
    logic [31:0] imm;
    logic        sf;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];

  instr_decode #(.REG_N(REG_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .we_c(we_c), .alu_op(alu_op),
    .imm_en(imm_en), .imm_val(imm_val), .set_flags(set_flags), .out_pc(out_pc),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .illegal(illegal)
  );

  // Reference decode written straight from the instruction-format rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int rot;
    logic [31:0] v;
    e.op  = ins[24:21];
    e.we  = !(e.op >= 4'd8 && e.op <= 4'd11);
    e.a   = ins[19:16];
    e.b   = ins[3:0];
    e.c   = ins[15:12];
    e.ie  = ins[25];
    e.sf  = ins[20];
    e.pc  = pc;
    v     = {24'd0, ins[7:0]};
    rot   = 2 * int'(ins[11:8]);
    e.imm = (rot == 0) ? v : ((v >> rot) | (v << (32 - rot)));
    e.ill = (ins[27:26] != 2'b00) || (ins[31:28] == 4'hF) || (e.we && int'(e.c) >= REG_N);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp_v);
  endtask

  // Monitor: pops one expectation per discard pulse or per issue handshake.
  always @(negedge clk) begin
    exp_t e;
    logic iss;
    iss = 1'b0;
    e   = '0;
    if (!rst_n) begin
      sbq.delete();
      pend_m = '0;
    end else begin
      if (illegal) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL illegal_unexpected: pulse with empty scoreboard");
        end else begin
          e = sbq.pop_front();
          chk("discard_was_illegal", e.ill, 1'b1);
        end
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL issue_unexpected: issue pc=%0h with empty scoreboard", out_pc);
        end else begin
          e   = sbq.pop_front();
          iss = 1'b1;
          chk("issue_was_legal", e.ill, 1'b0);
          chk("issue_fields",
              {addr_a, addr_b, addr_c, we_c, alu_op, imm_en, imm_val, set_flags},
              {e.a, e.b, e.c, e.we, e.op, e.ie, e.imm, e.sf});
          chk("issue_pc", out_pc, e.pc);
          chk("issue_hazard_free",
              pend_m[e.a] | (!e.ie & pend_m[e.b]) | (e.we & pend_m[e.c]), 1'b0);
        end
      end
      if (retire_valid && int'(retire_addr) < REG_N) pend_m[retire_addr] = 1'b0;
      if (iss && e.we) pend_m[e.c] = 1'b1;
    end
  end

  // One clock step; in random mode also randomizes back-pressure and retires.
  task automatic cycle();
    int k;
    @(posedge clk);
    #1;
    if (rnd_mode) begin
      out_ready    = ($urandom_range(0, 3) != 0);
      retire_valid = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        if (pend_m != 16'd0) begin
          do k = $urandom_range(0, REG_N - 1); while (!pend_m[k]);
          retire_valid = 1'b1;
          retire_addr  = 4'(k);
        end else if ($urandom_range(0, 4) == 0) begin
          retire_valid = 1'b1;
          retire_addr  = 4'($urandom_range(0, 15));
        end
      end
    end
  endtask

  // Present one instruction until accepted; returns just after the accept edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(ins, pc));
        done = 1'b1;
      end
      cycle();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL send_timeout: instr %08h never accepted", ins);
    end
  endtask

  task automatic retire(input logic [3:0] a);
    retire_valid = 1'b1;
    retire_addr  = a;
    cycle();
    retire_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) ins[27:26] = 2'b00;
    if ($urandom_range(0, 7) != 0) ins[31:28] = 4'hE;
    if ($urandom_range(0, 3) != 0) begin
      ins[19] = 1'b0;
      ins[15] = 1'b0;
      ins[3]  = 1'b0;
    end
    return ins;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; retire_valid = 1'b0; retire_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {out_valid, illegal, we_c, set_flags, imm_en, addr_a, addr_b, addr_c, alu_op}, '0);
    chk("reset_data", {imm_val, out_pc}, '0);
    chk("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    cycle();

    // ADD r1,r1,#5 with one-cycle latency
    send(32'hE2811005, 32'h100);
    chk("add_latency", out_valid, 1'b1);
    chk("add_fields", {addr_a, addr_c, imm_val, we_c, alu_op}, {4'd1, 4'd1, 32'd5, 1'b1, 4'b0100});
    cycle();
    retire(4'd1);

    // MOV r0,#0xFF000000 rotated immediate
    send(32'hE3A004FF, 32'h104);
    chk("mov_imm", imm_val, 32'hFF000000);
    chk("mov_ctrl", {imm_en, we_c, alu_op}, {1'b1, 1'b1, 4'b1101});
    cycle();
    retire(4'd0);

    // ADD r2,r0,r1 then SUB r3,r2,r4: RAW stall until r2 retires
    send(32'hE0802001, 32'h108);
    send(32'hE0423004, 32'h10C);
    chk("sub_stalled", {out_valid, in_ready}, 2'b00);
    cycle();
    cycle();
    chk("sub_still_stalled", out_valid, 1'b0);
    retire(4'd2);
    chk("sub_released", {out_valid, addr_a, addr_c}, {1'b1, 4'd2, 4'd3});
    cycle();
    retire(4'd3);

    // Branch is discarded with a single illegal pulse
    send(32'hEA000000, 32'h110);
    chk("branch_discard", {illegal, out_valid, in_ready}, 3'b101);
    cycle();
    chk("branch_pulse_end", illegal, 1'b0);

    // CMP r5,r6 does not mark r5 pending; MOV r5,#1 follows without stall
    send(32'hE1550006, 32'h114);
    chk("cmp_ctrl", {out_valid, we_c, set_flags, alu_op}, {1'b1, 1'b0, 1'b1, 4'b1010});
    send(32'hE3A05001, 32'h118);
    chk("mov_after_cmp", {out_valid, addr_c}, {1'b1, 4'd5});
    cycle();
    retire(4'd5);

    // Reset during a stall with r2 pending
    send(32'hE0802001, 32'h11C);
    send(32'hE0423004, 32'h120);
    chk("pre_reset_stall", out_valid, 1'b0);
    rst_n = 1'b0;
    cycle();
    chk("reset_in_stall", {out_valid, in_ready}, 2'b00);
    chk("reset_clears_fields", {addr_a, addr_b, addr_c, alu_op, we_c, imm_en, imm_val, out_pc}, '0);
    rst_n = 1'b1;
    send(32'hE0423004, 32'h124);
    chk("pending_cleared_by_reset", out_valid, 1'b1);
    cycle();
    retire(4'd3);
    repeat (2) cycle();

    // Randomized traffic with back-pressure and random retires
    rnd_mode = 1'b1;
    pc = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) cycle();
      send(rand_instr(), pc);
      pc += 32'd4;
    end
    for (int n = 0; n < 3000 && sbq.size() != 0; n++) cycle();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
